// File: rtl/trans_feeder.sv
`default_nettype none
// ============================================================================
// Module      : trans_feeder
// Description : Queues payment transactions in a small FIFO and presents them
//               one at a time to a downstream validator through a
//               valid/ack handshake. Marks the first transaction of each
//               block with a block-start flag and counts acknowledged
//               transactions. Defining TRANS_FEEDER_TIMEOUT_EN adds a
//               timeout/retry path that briefly drops valid_o and re-presents
//               the same word when no ack_i arrives in time.
// Revision    : 1.0 - initial release
// ============================================================================
module trans_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [47:0]  in_sender_id,
    input  logic [47:0]  in_receiver_id,
    input  logic [21:0]  in_amount,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         block_start_i,
    output logic [127:0] data_o,
    output logic         valid_o,
    input  logic         ack_i,
    output logic [31:0]  sent_cnt_o,
    output logic [15:0]  timeout_cnt_o
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // Address width of the storage array; pointers carry one extra bit so
    // that full and empty can be told apart when the addresses match.
    localparam int c_addr_w  = $clog2(FIFO_DEPTH);
    localparam int c_ptr_w   = c_addr_w + 1;
    // Stored entry: {sender[47:0], receiver[47:0], amount[21:0]}
    localparam int c_entry_w = 48 + 48 + 22;
    // Registered part of the output word: entry plus the block-start flag.
    localparam int c_word_w  = c_entry_w + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // FSM encoding
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_send  = 2'd1;
`ifdef TRANS_FEEDER_TIMEOUT_EN
    localparam logic [1:0] c_retry = 2'd2;

    // The wait counter only has to reach TIMEOUT-1.
    localparam int                  c_wait_w   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(TIMEOUT - 1);
    localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);
`endif

    // Elaboration-time guard against unusable parameter values.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
        $error("trans_feeder: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;

    logic [1:0]           r_state;
    logic [c_word_w-1:0]  r_word;
    logic                 r_valid;
    logic                 r_bs_pending;
    logic [31:0]          r_sent_cnt;
    logic [15:0]          r_timeout_cnt;

`ifdef TRANS_FEEDER_TIMEOUT_EN
    logic [c_wait_w-1:0]  r_wait_cnt;
    logic                 w_expire;
`endif

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ack;
    logic [c_entry_w-1:0] w_head;

    // ------------------------------------------------------------------------
    // FIFO status and handshake qualifiers
    // ------------------------------------------------------------------------
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                      (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign in_ready = ~w_full;

    // in_ready is derived from the registered pointers only, so a pop in the
    // same cycle never opens a slot for a push on a full FIFO, and a push
    // into an empty FIFO is only visible to the FSM one cycle later.
    assign w_push   = in_valid & ~w_full & ~rst;
    assign w_pop    = (r_state == c_idle) & ~w_empty & ~rst;

    // An acknowledge only counts while a word is actually being presented.
    assign w_ack    = (r_state == c_send) & ack_i;

    assign w_head   = r_mem[r_rd_ptr[c_addr_w-1:0]];

`ifdef TRANS_FEEDER_TIMEOUT_EN
    // Expiry is suppressed by a simultaneous ack so the ack is honoured.
    assign w_expire = (r_state == c_send) & ~ack_i & (r_wait_cnt == c_wait_max);
`endif

    // Write accepted transactions into the storage array (no reset needed).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= {in_sender_id, in_receiver_id, in_amount};
        end
    end

    // Advance the write and read pointers on accepted pushes and pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Track whether the next loaded word opens a new block; a request seen
    // in the load cycle itself belongs to the following word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bs_pending <= 1'b1;
        end else if (w_pop) begin
            r_bs_pending <= block_start_i;
        end else if (block_start_i) begin
            r_bs_pending <= 1'b1;
        end
    end

    // Presentation FSM: load from the FIFO in IDLE, hold in SEND until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_pop) begin
                        r_word  <= {w_head, r_bs_pending};
                        r_valid <= 1'b1;
                        r_state <= c_send;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                c_send: begin
                    if (ack_i) begin
                        r_valid <= 1'b0;
                        r_state <= c_idle;
`ifdef TRANS_FEEDER_TIMEOUT_EN
                    end else if (w_expire) begin
                        r_valid <= 1'b0;
                        r_state <= c_retry;
`endif
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
`ifdef TRANS_FEEDER_TIMEOUT_EN
                c_retry: begin
                    // Re-present the unchanged word after one quiet cycle.
                    r_valid <= 1'b1;
                    r_state <= c_send;
                end
`endif
                default: begin
                    r_valid <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Count acknowledged transactions; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sent_cnt <= '0;
        end else if (w_ack) begin
            r_sent_cnt <= r_sent_cnt + 32'd1;
        end
    end

`ifdef TRANS_FEEDER_TIMEOUT_EN
    // Cycles spent in SEND without ack; restarts on every load and retry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_pop || (r_state == c_retry)) begin
            r_wait_cnt <= '0;
        end else if ((r_state == c_send) && !ack_i && (r_wait_cnt != c_wait_max)) begin
            r_wait_cnt <= r_wait_cnt + c_wait_one;
        end
    end

    // Count retries, saturating at the top of the 16-bit range.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_cnt <= '0;
        end else if (w_expire && (r_timeout_cnt != 16'hFFFF)) begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
    end
`else
    // Without the retry path no timeouts can occur.
    assign r_timeout_cnt = 16'd0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data_o        = {r_word, 9'b0};
    assign valid_o       = r_valid;
    assign sent_cnt_o    = r_sent_cnt;
    assign timeout_cnt_o = r_timeout_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trans_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_trans_feeder
// Description : Self-checking bench for trans_feeder. Expected output words
//               are queued when transactions are pushed and compared when the
//               feeder presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trans_feeder;

    localparam int DEPTH      = 8;
    localparam int TB_TIMEOUT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [47:0]  in_sender_id;
    logic [47:0]  in_receiver_id;
    logic [21:0]  in_amount;
    logic         in_valid;
    logic         in_ready;
    logic         block_start_i;
    logic [127:0] data_o;
    logic         valid_o;
    logic         ack_i;
    logic [31:0]  sent_cnt_o;
    logic [15:0]  timeout_cnt_o;

    always #5 clk = ~clk;

    trans_feeder #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_sender_id   (in_sender_id),
        .in_receiver_id (in_receiver_id),
        .in_amount      (in_amount),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .block_start_i  (block_start_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ack_i          (ack_i),
        .sent_cnt_o     (sent_cnt_o),
        .timeout_cnt_o  (timeout_cnt_o)
    );

    typedef struct {
        logic [47:0] snd;
        logic [47:0] rcv;
        logic [21:0] amt;
        bit          bs_hold;      // pulse block_start_i while this word is held
        bit          bs_after_ack; // pulse block_start_i in the cycle after its ack
        bit          exp_b9;       // expected block-start bit of this word
    } vec_t;

    vec_t         vecs [14];
    logic [127:0] exp_q [$];
    int           n_vec = 0;
    int           n_bad = 0;

    function automatic logic [127:0] mk_word(input logic [47:0] s, input logic [47:0] r,
                                             input logic [21:0] a, input bit b9);
        return {s, r, a, b9, 9'b0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_txn(input logic [47:0] s, input logic [47:0] r, input logic [21:0] a,
                            input bit b9, input bit track);
        int budget;
        budget         = 100;
        in_sender_id   = s;
        in_receiver_id = r;
        in_amount      = a;
        in_valid       = 1'b1;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_wait: in_ready got 0, expected 1 within 100 cycles");
        end
        tick();
        in_valid = 1'b0;
        if (track) exp_q.push_back(mk_word(s, r, a, b9));
    endtask

    task automatic wait_valid(input string name, output int waited);
        waited = 0;
        while (!valid_o && waited < 50) begin
            tick();
            waited++;
        end
        check({name, "_valid"}, valid_o, 1'b1);
    endtask

    task automatic take(input string name, input int hold, input bit bs_hold,
                        input bit bs_after_ack, output int waited);
        logic [127:0] exp;
        int           w2;
        wait_valid(name, waited);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_sb: got word 0x%0h, expected no word", name, data_o);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check({name, "_data"}, data_o, exp);
        for (int i = 0; i < hold; i++) begin
            if (bs_hold && i == 0) block_start_i = 1'b1;
            tick();
            block_start_i = 1'b0;
            check({name, "_hold"}, data_o, exp);
        end
        // A retry may have dropped valid; acknowledge only a presented word.
        w2 = 0;
        while (!valid_o && w2 < 20) begin
            tick();
            w2++;
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check({name, "_ack_drop"}, valid_o, 1'b0);
        if (bs_after_ack) begin
            block_start_i = 1'b1;
            tick();
            block_start_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish, expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        int w;

        // Full-FIFO burst: only the first word after reset opens a block.
        for (int i = 0; i < 9; i++) begin
            vecs[i].snd          = 48'h1000_0000_0000 + 48'(i);
            vecs[i].rcv          = 48'h2000_0000_0000 + 48'(i * 3);
            vecs[i].amt          = 22'(100 + i * 7);
            vecs[i].bs_hold      = 1'b0;
            vecs[i].bs_after_ack = 1'b0;
            vecs[i].exp_b9       = (i == 0);
        end
        // Block-start placement: pulse while word 2 is held marks word 3;
        // pulse in word 4's load cycle marks word 5, not word 4.
        vecs[9]  = '{48'hAAAA_0000_0001, 48'hBBBB_0000_0001, 22'h3FFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{48'hAAAA_0000_0002, 48'hBBBB_0000_0002, 22'h000001, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 22'h155555, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF, 22'h2AAAAA, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{48'h1234_5678_9ABC, 48'hCBA9_8765_4321, 22'h000000, 1'b0, 1'b0, 1'b1};

        rst            = 1'b1;
        in_sender_id   = '0;
        in_receiver_id = '0;
        in_amount      = '0;
        in_valid       = 1'b0;
        block_start_i  = 1'b0;
        ack_i          = 1'b0;

        // ---------------- reset state and single transaction ----------------
        do_reset();
        check("rst_valid",   valid_o,       1'b0);
        check("rst_data",    data_o,        128'd0);
        check("rst_ready",   in_ready,      1'b1);
        check("rst_sent",    sent_cnt_o,    32'd0);
        check("rst_timeout", timeout_cnt_o, 16'd0);

        in_sender_id   = 48'hA;
        in_receiver_id = 48'hB;
        in_amount      = 22'd50;
        in_valid       = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_after_push", valid_o, 1'b0);
        tick();
        check("lat_next_edge", valid_o, 1'b1);
        check("single_data", data_o, mk_word(48'hA, 48'hB, 22'd50, 1'b1));
        tick();
        tick();
        check("single_hold_valid", valid_o, 1'b1);
        check("single_hold_data", data_o, mk_word(48'hA, 48'hB, 22'd50, 1'b1));
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check("single_ack_drop", valid_o, 1'b0);
        check("single_sent", sent_cnt_o, 32'd1);

        // ---------------- burst filling the FIFO ----------------
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push_txn(vecs[i].snd, vecs[i].rcv, vecs[i].amt, vecs[i].exp_b9, 1'b1);
            // One word has already moved into the output register.
            if (i == 7) check("ready_before_full", in_ready, 1'b1);
            if (i == 8) check("ready_when_full", in_ready, 1'b0);
        end
        // Offer an extra word that must be refused even during the pop cycle.
        in_sender_id   = 48'hDEAD_DEAD_DEAD;
        in_receiver_id = 48'hBEEF_BEEF_BEEF;
        in_amount      = 22'h0F0F0F;
        in_valid       = 1'b1;
        take("burst_0", 3, vecs[0].bs_hold, vecs[0].bs_after_ack, w);
        check("full_pop_cycle_ready", in_ready, 1'b0);
        tick();
        in_valid = 1'b0;
        check("ready_after_pop", in_ready, 1'b1);
        for (int i = 1; i < 9; i++) begin
            take($sformatf("burst_%0d", i), 3, vecs[i].bs_hold, vecs[i].bs_after_ack, w);
            if (i >= 2) check($sformatf("gap_%0d", i), w, 1);
        end
        check("burst_sent", sent_cnt_o, 32'd9);
        tick();
        tick();
        tick();
        check("refused_not_emitted", valid_o, 1'b0);
        check("burst_sb_empty", exp_q.size(), 0);

        // ---------------- block-start placement ----------------
        for (int i = 9; i < 14; i++) begin
            push_txn(vecs[i].snd, vecs[i].rcv, vecs[i].amt, vecs[i].exp_b9, 1'b1);
        end
        for (int i = 9; i < 14; i++) begin
            take($sformatf("bs_%0d", i), 2, vecs[i].bs_hold, vecs[i].bs_after_ack, w);
        end
        check("bs_sent", sent_cnt_o, 32'd14);

        // ---------------- stray ack and reset during SEND ----------------
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check("stray_ack_sent", sent_cnt_o, 32'd14);
        check("stray_ack_valid", valid_o, 1'b0);

        push_txn(48'h51, 48'h52, 22'd53, 1'b0, 1'b0);
        push_txn(48'h61, 48'h62, 22'd63, 1'b0, 1'b0);
        wait_valid("pre_rst", w);
        rst = 1'b1;
        tick();
        check("midrst_valid", valid_o, 1'b0);
        check("midrst_data", data_o, 128'd0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        tick();
        tick();
        check("midrst_fifo_empty", valid_o, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        check("midrst_sent", sent_cnt_o, 32'd0);
        push_txn(48'h71, 48'h72, 22'd73, 1'b1, 1'b1);
        take("after_rst", 1, 1'b0, 1'b0, w);
        check("after_rst_sent", sent_cnt_o, 32'd1);

        // ---------------- timeout behaviour ----------------
        do_reset();
        push_txn(48'hC0FFEE, 48'hFACADE, 22'd999, 1'b1, 1'b1);
        wait_valid("to", w);
`ifdef TRANS_FEEDER_TIMEOUT_EN
        for (int r = 1; r <= 2; r++) begin
            for (int k = 0; k < TB_TIMEOUT; k++) begin
                check($sformatf("to_high_%0d_%0d", r, k), valid_o, 1'b1);
                check($sformatf("to_data_%0d_%0d", r, k), data_o,
                      mk_word(48'hC0FFEE, 48'hFACADE, 22'd999, 1'b1));
                tick();
            end
            check($sformatf("to_low_%0d", r), valid_o, 1'b0);
            check($sformatf("to_cnt_%0d", r), timeout_cnt_o, 16'(r));
            tick();
        end
        take("to_final", 0, 1'b0, 1'b0, w);
        check("to_final_cnt", timeout_cnt_o, 16'd2);
`else
        for (int k = 0; k < 10; k++) tick();
        check("noto_still_valid", valid_o, 1'b1);
        check("noto_cnt", timeout_cnt_o, 16'd0);
        take("noto_final", 0, 1'b0, 1'b0, w);
`endif
        check("to_sent", sent_cnt_o, 32'd1);
        check("final_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
